input_conditioner: RTL and testbench

Front-end conditioning stage for the board's user inputs, placed directly upstream of the LED pattern generator. It synchronises the raw push-button and 3-bit slide switch to the system clock and debounces both. It delivers a clean one-cycle press pulse, a debounced button level, and a stable switch bus with a change strobe. The pattern generator consumes `btn_pulse` (start/arm) and `sw_stable` (pattern width) instead of raw pins.

---
 rtl/input_conditioner.sv | 162 ++++++++++++++++
 tb/tb_input_conditioner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// input_conditioner
// Synchronises and debounces a push-button and a slide-switch bus, producing
// a clean button level, press/release strobes and a stable switch bus.
// Revision: 1.0
// ============================================================================
module input_conditioner #(
    parameter logic [31:0] DEBOUNCE_CNT = 32'd1_000_000,
    parameter int          SW_WIDTH     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                button,
    input  logic [SW_WIDTH-1:0] switch,
    output logic                btn_level,
    output logic                btn_pulse,
    output logic                btn_release,
    output logic [SW_WIDTH-1:0] sw_stable,
    output logic                sw_changed
);

    localparam logic [31:0] C_LAST = DEBOUNCE_CNT - 32'd1;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } btn_state_t;

    logic                btn_meta_q, btn_sync_q;
    logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q;

    btn_state_t          state_q, state_d;
    logic [31:0]         bcnt_q, bcnt_d;
    logic                level_q, level_d;
    logic                pulse_q, pulse_d;
    logic                release_q, release_d;

    logic [SW_WIDTH-1:0] sw_cand_q, sw_cand_d;
    logic [SW_WIDTH-1:0] sw_stable_q, sw_stable_d;
    logic [31:0]         scnt_q, scnt_d;
    logic                sw_changed_q, sw_changed_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            btn_meta_q <= button;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= switch;
            sw_sync_q  <= sw_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bcnt_q    <= 32'd0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
        end
    end

    // A bounce back to the previous level in either wait state abandons the debounce.
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        level_d   = level_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (btn_sync_q) begin
                    state_d = S_PRESS_WAIT;
                    bcnt_d  = 32'd0;
                end
            end
            S_PRESS_WAIT: begin
                if (!btn_sync_q) begin
                    state_d = S_IDLE;
                end else if (bcnt_q == C_LAST) begin
                    state_d = S_PRESSED;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + 32'd1;
                end
            end
            S_PRESSED: begin
                if (!btn_sync_q) begin
                    state_d = S_RELEASE_WAIT;
                    bcnt_d  = 32'd0;
                end
            end
            S_RELEASE_WAIT: begin
                if (btn_sync_q) begin
                    state_d = S_PRESSED;
                end else if (bcnt_q == C_LAST) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    bcnt_d = bcnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_cand_q    <= '0;
            sw_stable_q  <= '0;
            scnt_q       <= 32'd0;
            sw_changed_q <= 1'b0;
        end else begin
            sw_cand_q    <= sw_cand_d;
            sw_stable_q  <= sw_stable_d;
            scnt_q       <= scnt_d;
            sw_changed_q <= sw_changed_d;
        end
    end

    // Any bit that moves restarts the count against the new candidate value.
    always_comb begin
        sw_cand_d    = sw_cand_q;
        sw_stable_d  = sw_stable_q;
        scnt_d       = scnt_q;
        sw_changed_d = 1'b0;
        if (sw_sync_q != sw_cand_q) begin
            sw_cand_d = sw_sync_q;
            scnt_d    = 32'd0;
        end else if (sw_cand_q != sw_stable_q) begin
            if (scnt_q == C_LAST) begin
                sw_stable_d  = sw_cand_q;
                sw_changed_d = 1'b1;
            end else begin
                scnt_d = scnt_q + 32'd1;
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_pulse   = pulse_q;
    assign btn_release = release_q;
    assign sw_stable   = sw_stable_q;
    assign sw_changed  = sw_changed_q;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// tb_input_conditioner
// Directed and randomised checks of input_conditioner against a window model.
// Revision: 1.0
// ============================================================================
module tb_input_conditioner;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button = 1'b1;
    logic [2:0] switch = 3'b101;
    logic       btn_level, btn_pulse, btn_release, sw_changed;
    logic [2:0] sw_stable;

    int errors = 0;
    int checks = 0;

    input_conditioner #(
        .DEBOUNCE_CNT (32'd4),
        .SW_WIDTH     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button      (button),
        .switch      (switch),
        .btn_level   (btn_level),
        .btn_pulse   (btn_pulse),
        .btn_release (btn_release),
        .sw_stable   (sw_stable),
        .sw_changed  (sw_changed)
    );

    always #5 clk = ~clk;

    // Reference: an output flips once the conditioned input has disagreed
    // with it for N+1 consecutive edges, seen two edges after raw sampling.
    logic       mb_meta = 1'b0, mb_sync = 1'b0;
    logic [2:0] ms_meta = '0, ms_sync = '0;
    logic       bq[$];
    logic [2:0] sq[$];
    logic       m_level = 1'b0, m_pulse = 1'b0, m_rel = 1'b0, m_changed = 1'b0;
    logic [2:0] m_stable = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mb_meta = 1'b0; mb_sync = 1'b0;
        ms_meta = '0;   ms_sync = '0;
        bq.delete();    sq.delete();
        m_level = 1'b0; m_pulse = 1'b0; m_rel = 1'b0;
        m_stable = '0;  m_changed = 1'b0;
    endtask

    task automatic model_edge();
        logic       all_diff, all_same;
        bq.push_back(mb_sync);
        sq.push_back(ms_sync);
        if (bq.size() > N + 1) void'(bq.pop_front());
        if (sq.size() > N + 1) void'(sq.pop_front());
        mb_sync = mb_meta; mb_meta = button;
        ms_sync = ms_meta; ms_meta = switch;
        m_pulse = 1'b0; m_rel = 1'b0; m_changed = 1'b0;
        all_diff = (bq.size() == N + 1);
        foreach (bq[i]) if (bq[i] == m_level) all_diff = 1'b0;
        if (all_diff) begin
            m_level = ~m_level;
            m_pulse = m_level;
            m_rel   = ~m_level;
        end
        all_same = (sq.size() == N + 1) && (sq[0] != m_stable);
        foreach (sq[i]) if (sq[i] != sq[0]) all_same = 1'b0;
        if (all_same) begin
            m_stable  = sq[0];
            m_changed = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        chk("btn_level",   {31'd0, btn_level},   {31'd0, m_level});
        chk("btn_pulse",   {31'd0, btn_pulse},   {31'd0, m_pulse});
        chk("btn_release", {31'd0, btn_release}, {31'd0, m_rel});
        chk("sw_stable",   {29'd0, sw_stable},   {29'd0, m_stable});
        chk("sw_changed",  {31'd0, sw_changed},  {31'd0, m_changed});
    endtask

    // Edge 0 is the first edge sampling the current input values.
    task automatic measure(input int n, output int pc, output int pe,
                           output int rc, output int re, output int cc, output int ce);
        pc = 0; pe = -1; rc = 0; re = -1; cc = 0; ce = -1;
        for (int i = 0; i < n; i++) begin
            step();
            if (btn_pulse)   begin pc++; if (pe < 0) pe = i; end
            if (btn_release) begin rc++; if (re < 0) re = i; end
            if (sw_changed)  begin cc++; if (ce < 0) ce = i; end
        end
    endtask

    initial begin
        int pc, pe, rc, re, cc, ce, bounce_p, bounce_c;
        int flip_div;
        model_reset();

        // Reset held with inputs active; outputs must stay low.
        repeat (3) step();
        rst = 1'b0;
        measure(12, pc, pe, rc, re, cc, ce);
        chk("rst_pulse_cnt",  pc, 1);
        chk("rst_pulse_edge", pe, 6);
        chk("rst_sw_edge",    ce, 6);
        chk("rst_sw_val",     {29'd0, sw_stable}, 32'd5);

        // Clean press, hold and release.
        button = 1'b0; switch = 3'b000;
        measure(12, pc, pe, rc, re, cc, ce);
        chk("rel0_edge", re, 6);
        button = 1'b1;
        measure(20, pc, pe, rc, re, cc, ce);
        chk("press_cnt",  pc, 1);
        chk("press_edge", pe, 6);
        chk("press_lvl",  {31'd0, btn_level}, 32'd1);
        button = 1'b0;
        measure(12, pc, pe, rc, re, cc, ce);
        chk("release_cnt",  rc, 1);
        chk("release_edge", re, 6);
        chk("release_lvl",  {31'd0, btn_level}, 32'd0);

        // Bounce 1,0,1,0 in 2-cycle segments, then hold high.
        bounce_p = 0;
        for (int s = 0; s < 4; s++) begin
            button = ~s[0];
            measure(2, pc, pe, rc, re, cc, ce);
            bounce_p += pc;
        end
        chk("bounce_early", bounce_p, 0);
        button = 1'b1;
        measure(12, pc, pe, rc, re, cc, ce);
        chk("bounce_cnt",  pc, 1);
        chk("bounce_edge", pe, 6);
        button = 1'b0;
        measure(12, pc, pe, rc, re, cc, ce);

        // Short glitch.
        button = 1'b1;
        measure(3, pc, pe, rc, re, cc, ce);
        bounce_p = pc;
        button = 1'b0;
        measure(10, pc, pe, rc, re, cc, ce);
        chk("glitch_pulse", bounce_p + pc, 0);
        chk("glitch_lvl",   {31'd0, btn_level}, 32'd0);

        // Switch bounce 000 -> 011 -> 010 -> 011.
        switch = 3'b011;
        measure(2, pc, pe, rc, re, cc, ce);
        bounce_c = cc;
        switch = 3'b010;
        measure(2, pc, pe, rc, re, cc, ce);
        bounce_c += cc;
        chk("swb_early", bounce_c, 0);
        switch = 3'b011;
        measure(12, pc, pe, rc, re, cc, ce);
        chk("swb_cnt",  cc, 1);
        chk("swb_edge", ce, 6);
        chk("swb_val",  {29'd0, sw_stable}, 32'd3);

        // Reset in PRESS_WAIT with bcnt=2, button kept high.
        button = 1'b1;
        measure(5, pc, pe, rc, re, cc, ce);
        bounce_p = pc;
        rst = 1'b1;
        measure(2, pc, pe, rc, re, cc, ce);
        chk("rstmid_pulse", bounce_p + pc, 0);
        rst = 1'b0;
        measure(12, pc, pe, rc, re, cc, ce);
        chk("rstmid_cnt",  pc, 1);
        chk("rstmid_edge", pe, 6);

        // Randomised phases alternating between bouncy and calm inputs.
        for (int i = 0; i < 3000; i++) begin
            flip_div = ((i / 200) % 2 == 0) ? 3 : 12;
            if ($urandom_range(0, flip_div - 1) == 0) button = ~button;
            if ($urandom_range(0, flip_div - 1) == 0) switch = 3'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
